// File: rtl/alu_pkg.sv
// Shared ALU opcodes and arbiter state type, also used by the decoder/controller.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  // 110 and 111 are the only illegal encodings.
  function automatic logic opc_illegal(input logic [2:0] opc);
    return opc[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: wrap-around add/sub, bitwise ops, signed set-less-than.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   opc_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o,
  output logic         zero_o
);

  always_comb begin
    y_o = '0;
    unique case (opc_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLT: y_o = {{(N-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, one op in flight,
// result held in registers for a backpressured response port.
//
//   state | meaning
//   IDLE  | arbitrating; the granted requester sees ready
//   EXEC  | operands registered, ALU evaluating
//   RESP  | result held, rsp_valid high until rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_opc,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_opc,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_out,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic         busy
);

  arb_state_t   state_q, state_d;
  logic         last_grant_q;
  logic [2:0]   opc_q;
  logic [N-1:0] a_q, b_q;
  logic         id_q, err_q;
  logic         rsp_id_q, rsp_zero_q, rsp_err_q;
  logic [N-1:0] rsp_out_q;

  logic         grant, gnt_id;
  logic [N-1:0] alu_y;
  logic         alu_zero;

  // Reset is gated into grant so no handshake completes on a reset edge.
  always_comb begin
    grant  = 1'b0;
    gnt_id = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant  = 1'b1;
        gnt_id = ~last_grant_q;
      end else if (req0_valid || req1_valid) begin
        grant  = 1'b1;
        gnt_id = req1_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant && !gnt_id;
    req1_ready = grant && gnt_id;
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      opc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
    end else if (grant) begin
      last_grant_q <= gnt_id;
      opc_q        <= gnt_id ? req1_opc : req0_opc;
      a_q          <= gnt_id ? req1_a : req0_a;
      b_q          <= gnt_id ? req1_b : req0_b;
      id_q         <= gnt_id;
      err_q        <= opc_illegal(gnt_id ? req1_opc : req0_opc);
    end
  end

  alu_arbiter_alu #(.N(N)) u_alu (
    .opc_i  (opc_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  // Illegal ops report a forced zero result, independent of what the ALU produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id_q   <= 1'b0;
      rsp_out_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_id_q   <= id_q;
      rsp_out_q  <= err_q ? '0 : alu_y;
      rsp_zero_q <= err_q ? 1'b1 : alu_zero;
      rsp_err_q  <= err_q;
    end
  end

  assign rsp_id   = rsp_id_q;
  assign rsp_out  = rsp_out_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_opc, req1_opc;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_out;
  logic         rsp_zero, rsp_err, busy;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_opc   (req0_opc),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_opc   (req1_opc),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an op is "in flight" for one cycle after accept, then "held" until taken.
  bit           m_inflight, m_held, m_last, m_post_rst;
  bit           e_id, e_zero, e_err;
  logic [N-1:0] e_out;
  int           grants[$];
  logic [N-1:0] last_out;
  bit           last_id, last_zero, last_err;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_result(input logic [2:0] opc, input logic [N-1:0] a,
                                              input logic [N-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (opc)
      3'd0:    return N'(sa + sb);
      3'd1:    return N'(sa - sb);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? N'(1) : N'(0);
      default: return N'(0);
    endcase
  endfunction

  // Called with inputs already driven after a falling edge; checks, then advances the model
  // past the coming rising edge.
  task automatic step();
    bit idle, any, win;
    #1;
    idle = !m_inflight && !m_held;
    any  = !rst && idle && (req0_valid || req1_valid);
    win  = (req0_valid && req1_valid) ? !m_last : req1_valid;
    check("req0_ready", req0_ready, any && !win);
    check("req1_ready", req1_ready, any && win);
    check("busy", busy, !idle);
    check("rsp_valid", rsp_valid, m_held);
    if (m_held) begin
      check("rsp_id", rsp_id, e_id);
      check("rsp_out", rsp_out, e_out);
      check("rsp_zero", rsp_zero, e_zero);
      check("rsp_err", rsp_err, e_err);
    end
    if (m_post_rst) begin
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_out", rsp_out, 0);
      check("rst_rsp_zero", rsp_zero, 0);
      check("rst_rsp_err", rsp_err, 0);
    end
    m_post_rst = 0;
    if (rst) begin
      m_inflight = 0;
      m_held     = 0;
      m_last     = 1;
      m_post_rst = 1;
    end else if (m_held) begin
      if (rsp_ready) begin
        m_held    = 0;
        last_out  = rsp_out;
        last_id   = rsp_id;
        last_zero = rsp_zero;
        last_err  = rsp_err;
      end
    end else if (m_inflight) begin
      m_inflight = 0;
      m_held     = 1;
    end else if (any) begin
      logic [2:0] opc;
      opc        = win ? req1_opc : req0_opc;
      e_id       = win;
      e_err      = (opc >= 3'd6);
      e_out      = ref_result(opc, win ? req1_a : req0_a, win ? req1_b : req0_b);
      e_zero     = (e_out == 0);
      m_last     = win;
      m_inflight = 1;
      grants.push_back(int'(win));
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_opc = 0; req1_opc = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
  endtask

  // One op from a single requester, then run until the response is taken.
  task automatic single_op(input bit id, input logic [2:0] opc, input logic [N-1:0] a,
                           input logic [N-1:0] b);
    idle_inputs();
    rsp_ready = 1;
    if (id) begin
      req1_valid = 1; req1_opc = opc; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_opc = opc; req0_a = a; req0_b = b;
    end
    step();
    idle_inputs();
    repeat (3) step();
  endtask

  initial begin
    rst = 1;
    rsp_ready = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    m_inflight = 0; m_held = 0; m_last = 1; m_post_rst = 1;
    rst = 0;
    step();

    single_op(0, 3'b000, 5, 7);
    check("add_out", last_out, 12);
    check("add_id", last_id, 0);
    check("add_zero", last_zero, 0);
    check("add_err", last_err, 0);

    single_op(1, 3'b001, 9, 9);
    check("sub_out", last_out, 0);
    check("sub_zero", last_zero, 1);
    check("sub_id", last_id, 1);

    single_op(0, 3'b101, 32'hFFFF_FFFF, 1);
    check("slt_out", last_out, 1);

    single_op(0, 3'b111, 32'h1234, 32'h5678);
    check("ill_err", last_err, 1);
    check("ill_out", last_out, 0);
    check("ill_zero", last_zero, 1);

    // Consumer stall with both requesters pushing.
    idle_inputs();
    req0_valid = 1; req0_opc = 3'b100; req0_a = 32'hF0F0; req0_b = 32'h0FF0;
    req1_valid = 1; req1_opc = 3'b011; req1_a = 32'h1;    req1_b = 32'h2;
    rsp_ready = 0;
    repeat (12) step();
    rsp_ready = 1;
    step();
    idle_inputs();
    repeat (4) step();

    // Reset while in EXEC drops the op; the next tie goes to req0.
    req1_valid = 1; req1_opc = 3'b000; req1_a = 1; req1_b = 1;
    step();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    repeat (4) step();

    grants.delete();
    req0_valid = 1; req0_opc = 3'b000; req0_a = 100; req0_b = 1;
    req1_valid = 1; req1_opc = 3'b001; req1_a = 100; req1_b = 1;
    repeat (12) step();
    check("alt_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) check($sformatf("alt_grant%0d", i), grants[i], i % 2);

    // Random traffic with occasional reset.
    for (int c = 0; c < 2000; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_opc   = $urandom_range(0, 7);
      req1_opc   = $urandom_range(0, 7);
      req0_a     = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 3)) : $urandom;
      req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a     = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 3)) : $urandom;
      req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      rsp_ready  = ($urandom_range(0, 9) < 7);
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the team's combinational ALU between two requesters, for example the main execute path and an address/branch helper. Uses a valid/ready handshake on each request port and a round-robin grant. Holds one operation in flight and registers its result for a single backpressured response port. Sits between the requesters and the ALU, and owns all ALU operand and opcode muxing.

## Interface
- N, 32, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_opc / req1_opc  in  3  ALU opcode
- req0_a, req0_b / req1_a, req1_b  in  N  signed operands
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester index of response
- rsp_out  out  N  ALU result
- rsp_zero  out  1  result equals zero
- rsp_err  out  1  illegal opcode
- busy  out  1  state is not IDLE

## Operation
- Opcodes:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 signed set-less-than (result 1/0)
  - 110 and 111 are illegal
- States:
  - IDLE -> EXEC on grant
  - EXEC -> RESP unconditionally
  - RESP -> IDLE on rsp_valid&rsp_ready
  - RESP holds otherwise
- req*_ready is asserted only in IDLE, and only for the granted requester; at most one ready is high per cycle.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester not in last_grant.
  - last_grant updates on every grant.
  - last_grant resets to 1, so req0 wins the first tie.
- On grant, register opc, a, b, id, and err (err = opc[2:1]==2'b11).
- EXEC:
  - ALU inputs come from the operand registers only.
  - At the EXEC->RESP edge, capture the ALU out and zero into the response registers.
  - If err is set, capture rsp_out=0 and rsp_zero=1 instead, without depending on the ALU output.
- RESP:
  - rsp_valid=1.
  - rsp_id, rsp_out, rsp_zero and rsp_err stay stable until the handshake.
- A requester that drops valid while not granted loses nothing; arbitration is re-evaluated every IDLE cycle.
- Arithmetic is N-bit wrap-around; no overflow flag.

## Timing
- Reset values:
  - state IDLE, last_grant 1
  - rsp_valid 0, rsp_id 0, rsp_out 0, rsp_zero 0, rsp_err 0
  - busy 0, req*_ready 0
- Accept on edge k.
- EXEC during cycle k..k+1.
- rsp_valid rises after edge k+1 (latency 2 cycles from accept).
- If rsp_ready is already high, the handshake occurs on edge k+2. IDLE resumes, and the next accept is possible on edge k+3, giving a best-case throughput of 1 op per 3 cycles.
- Consumer stall: RESP holds indefinitely and no new request is accepted (both ready low).
- Both valid with equal priority every cycle: grants strictly alternate 0,1,0,1.
- rst asserted in any state:
  - Next edge returns to IDLE with reset values.
  - Any in-flight operation is dropped with no response.
  - last_grant returns to 1.
- rst has priority over simultaneous handshakes.

## Structure
- Shared package alu_pkg holds:
  - localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT (3-bit)
  - arb_state_t enum {IDLE, EXEC, RESP}
- Package is shared with the decoder/controller.
- One sub-module: the existing ALU, instantiated once with parameter N. Its zero output feeds rsp_zero.
- Arbiter FSM, grant logic and registers live in alu_arbiter itself.

## Test plan
- Reset, then req0 add a=5 b=7, rsp_ready=1:
  - req0_ready on the accept edge.
  - rsp_valid two cycles later with rsp_id=0, rsp_out=12, rsp_zero=0, rsp_err=0.
- req1 sub a=9 b=9: rsp_out=0, rsp_zero=1. Then slt a=-1 b=1: rsp_out=1.
- Both valid continuously, rsp_ready=1:
  - Grants are req0, req1, req0, req1.
  - rsp_id sequence is 0,1,0,1.
  - Never two readies in one cycle.
- rsp_ready held low for 10 cycles after a response:
  - rsp fields stable throughout.
  - req*_ready stay 0.
  - The handshake on cycle 11 returns to IDLE.
- req0 opc=3'b111: rsp_err=1, rsp_out=0, rsp_zero=1, with no X on any response output.
- rst pulsed in EXEC: no rsp_valid afterwards. The next tie grants req0 first, and all outputs equal reset values the cycle after reset.
